text_console_writer: RTL and testbench

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

---
 rtl/text_console_writer.sv | 134 +++++++++++++
 tb/tb_text_console_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// Write side of the row-major character buffer: turns a stream of ASCII codes
// into registered cell writes, tracks the cursor, and blanks the buffer on form feed and reset.
module text_console_writer #(
  parameter int COLS   = 40,
  parameter int ROWS   = 8,
  parameter int ADDR_W = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       char_valid,
  input  logic [7:0]                 char_code,
  output logic                       char_ready,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 wr_data,
  output logic [$clog2(COLS)-1:0]    cur_col,
  output logic [$clog2(ROWS)-1:0]    cur_row,
  output logic                       busy
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CELLS = COLS * ROWS;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  generate
    if (CELLS > (1 << ADDR_W)) begin : g_param_check
      $error("text_console_writer: COLS*ROWS exceeds 2**ADDR_W");
    end
  endgenerate

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;

  logic                accept;
  logic                is_print, is_lf, is_bs, is_ff;
  logic                col_last, last_cell;
  logic [RW-1:0]       row_next;
  logic [ADDR_W-1:0]   cell_addr;

  // Code classification and cursor arithmetic, all relative to the current cursor.
  assign accept    = char_valid && char_ready;
  assign is_print  = (char_code >= CH_SPACE) && (char_code <= CH_TILDE);
  assign is_lf     = (char_code == CH_LF);
  assign is_bs     = (char_code == CH_BS);
  assign is_ff     = (char_code == CH_FF);
  assign col_last  = (cur_col == CW'(COLS - 1));
  assign row_next  = (cur_row == RW'(ROWS - 1)) ? '0 : cur_row + RW'(1);
  assign cell_addr = ADDR_W'(cur_row) * ADDR_W'(COLS) + ADDR_W'(cur_col);
  assign last_cell = (clr_cnt == ADDR_W'(CELLS - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept && is_ff) state_nxt = CLEAR;
      CLEAR: if (last_cell)       state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    char_ready = (state == IDLE);
    busy       = (state == CLEAR);
  end

  // Write port, cursor and clear counter. Write strobe defaults low every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      cur_col <= '0;
      cur_row <= '0;
      clr_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        CLEAR: begin
          wr_en   <= 1'b1;
          wr_addr <= clr_cnt;
          wr_data <= CH_SPACE;
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (last_cell) begin
            clr_cnt <= '0;
            cur_col <= '0;
            cur_row <= '0;
          end
        end
        IDLE: begin
          if (accept) begin
            if (is_print) begin
              wr_en   <= 1'b1;
              wr_addr <= cell_addr;
              wr_data <= char_code;
              if (col_last) begin
                cur_col <= '0;
                cur_row <= row_next;
              end else begin
                cur_col <= cur_col + CW'(1);
              end
            end else if (is_lf) begin
              cur_col <= '0;
              cur_row <= row_next;
            end else if (is_bs) begin
              // Backspace erases the cell it steps back onto; at column 0 it is a no-op.
              if (cur_col != '0) begin
                cur_col <= cur_col - CW'(1);
                wr_en   <= 1'b1;
                wr_addr <= cell_addr - ADDR_W'(1);
                wr_data <= CH_SPACE;
              end
            end else if (is_ff) begin
              clr_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: directed table, clear/reset sequences, and a
// randomized stream checked against a cursor/cell model.
module tb_text_console_writer;

  localparam int COLS  = 40;
  localparam int ROWS  = 8;
  localparam int AW    = 9;
  localparam int CELLS = COLS * ROWS;

  logic          clk = 1'b0;
  logic          rst;
  logic          char_valid;
  logic [7:0]    char_code;
  logic          char_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [5:0]    cur_col;
  logic [2:0]    cur_row;
  logic          busy;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_code(char_code),
    .char_ready(char_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int m_col = 0;
  int m_row = 0;

  typedef struct {
    logic [7:0] code;
    bit         we;
    int         addr;
    logic [7:0] data;
    int         col;
    int         row;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  // One offered character in IDLE; the model decides the write and the new cursor.
  task automatic step(input bit v, input logic [7:0] code);
    bit e_we = 0;
    int e_addr = 0;
    logic [7:0] e_data = 8'h00;
    chk("ready_idle", int'(char_ready), 1);
    char_valid = v;
    char_code  = code;
    if (v) begin
      if (code >= 8'h20 && code <= 8'h7E) begin
        e_we = 1; e_addr = m_row * COLS + m_col; e_data = code;
        m_col++;
        if (m_col == COLS) begin m_col = 0; m_row = (m_row + 1) % ROWS; end
      end else if (code == 8'h0A) begin
        m_col = 0; m_row = (m_row + 1) % ROWS;
      end else if (code == 8'h08 && m_col > 0) begin
        m_col--;
        e_we = 1; e_addr = m_row * COLS + m_col; e_data = 8'h20;
      end
    end
    @(posedge clk); #1;
    char_valid = 1'b0;
    chk("model_we", int'(wr_en), int'(e_we));
    if (e_we) begin
      chk("model_addr", int'(wr_addr), e_addr);
      chk("model_data", int'(wr_data), int'(e_data));
    end
    chk("model_col", int'(cur_col), m_col);
    chk("model_row", int'(cur_row), m_row);
  endtask

  // Expects the full blanking sequence starting at the next edge.
  task automatic clear_run(input string nm);
    int bad = 0;
    for (int i = 0; i < CELLS; i++) begin
      @(posedge clk); #1;
      if (!wr_en || int'(wr_addr) != i || wr_data != 8'h20) bad++;
      if (i < CELLS - 1 && (!busy || char_ready)) bad++;
    end
    chk(nm, bad, 0);
    chk({nm, "_ready"}, int'(char_ready), 1);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_col"}, int'(cur_col), 0);
    chk({nm, "_row"}, int'(cur_row), 0);
    m_col = 0;
    m_row = 0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_we"}, int'(wr_en), 0);
    chk({nm, "_addr"}, int'(wr_addr), 0);
    chk({nm, "_data"}, int'(wr_data), 0);
    chk({nm, "_col"}, int'(cur_col), 0);
    chk({nm, "_row"}, int'(cur_row), 0);
    chk({nm, "_ready"}, int'(char_ready), 0);
    chk({nm, "_busy"}, int'(busy), 1);
  endtask

  initial begin
    logic [7:0] c;
    int r;
    rst = 1'b0;
    char_valid = 1'b0;
    char_code = 8'h00;

    tbl[0]  = '{8'h48, 1,   0, 8'h48, 1, 0};
    tbl[1]  = '{8'h49, 1,   1, 8'h49, 2, 0};
    tbl[2]  = '{8'h0A, 0,   0, 8'h00, 0, 1};
    tbl[3]  = '{8'h0A, 0,   0, 8'h00, 0, 2};
    tbl[4]  = '{8'h61, 1,  80, 8'h61, 1, 2};
    tbl[5]  = '{8'h62, 1,  81, 8'h62, 2, 2};
    tbl[6]  = '{8'h63, 1,  82, 8'h63, 3, 2};
    tbl[7]  = '{8'h64, 1,  83, 8'h64, 4, 2};
    tbl[8]  = '{8'h65, 1,  84, 8'h65, 5, 2};
    tbl[9]  = '{8'h08, 1,  84, 8'h20, 4, 2};
    tbl[10] = '{8'h0A, 0,   0, 8'h00, 0, 3};
    tbl[11] = '{8'h08, 0,   0, 8'h00, 0, 3};
    tbl[12] = '{8'h07, 0,   0, 8'h00, 0, 3};
    tbl[13] = '{8'hFF, 0,   0, 8'h00, 0, 3};
    tbl[14] = '{8'h7F, 0,   0, 8'h00, 0, 3};
    tbl[15] = '{8'h20, 1, 120, 8'h20, 1, 3};
    tbl[16] = '{8'h7E, 1, 121, 8'h7E, 2, 3};
    tbl[17] = '{8'h1F, 0,   0, 8'h00, 2, 3};
    tbl[18] = '{8'h00, 0,   0, 8'h00, 2, 3};
    tbl[19] = '{8'h0A, 0,   0, 8'h00, 0, 4};

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;
    clear_run("powerup_clear");

    for (int i = 0; i < 20; i++) begin
      step(1'b1, tbl[i].code);
      chk($sformatf("tbl%0d_we", i), int'(wr_en), int'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_addr", i), int'(wr_addr), tbl[i].addr);
        chk($sformatf("tbl%0d_data", i), int'(wr_data), int'(tbl[i].data));
      end
      chk($sformatf("tbl%0d_col", i), int'(cur_col), tbl[i].col);
      chk($sformatf("tbl%0d_row", i), int'(cur_row), tbl[i].row);
    end

    // Form feed with the producer holding valid: nothing may be taken until IDLE.
    char_valid = 1'b1;
    char_code  = 8'h0C;
    @(posedge clk); #1;
    chk("ff_no_write", int'(wr_en), 0);
    chk("ff_ready_low", int'(char_ready), 0);
    chk("ff_busy", int'(busy), 1);
    char_code = 8'h41;
    clear_run("ff_clear");
    @(posedge clk); #1;
    char_valid = 1'b0;
    chk("after_ff_we", int'(wr_en), 1);
    chk("after_ff_addr", int'(wr_addr), 0);
    chk("after_ff_data", int'(wr_data), 8'h41);
    chk("after_ff_col", int'(cur_col), 1);
    m_col = 1;
    m_row = 0;

    // Reset while the clear counter sits at 100.
    char_valid = 1'b1;
    char_code  = 8'h0C;
    @(posedge clk); #1;
    char_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("midclear_addr", int'(wr_addr), 99);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset("midclear_reset");
    rst = 1'b1;
    clear_run("restart_clear");

    for (int i = 0; i < 41; i++) step(1'b1, 8'($urandom_range(8'h20, 8'h7E)));
    chk("wrap41_addr", int'(wr_addr), 40);
    chk("wrap41_col", int'(cur_col), 1);
    chk("wrap41_row", int'(cur_row), 1);
    for (int i = 0; i < 6; i++) step(1'b1, 8'h0A);
    for (int i = 0; i < 39; i++) step(1'b1, 8'($urandom_range(8'h20, 8'h7E)));
    chk("corner_col", int'(cur_col), 39);
    chk("corner_row", int'(cur_row), 7);
    step(1'b1, 8'h5A);
    chk("corner_addr", int'(wr_addr), 319);
    chk("corner_wrap_col", int'(cur_col), 0);
    chk("corner_wrap_row", int'(cur_row), 0);

    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      c = 8'($urandom_range(8'h20, 8'h7E));
      else if (r <= 7) c = 8'h08;
      else if (r == 8) c = 8'h0A;
      else begin
        c = 8'($urandom);
        if (c == 8'h0C) c = 8'h0D;
      end
      step($urandom_range(0, 3) != 0, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
